// File: rtl/pipe_fetch_queue_pkg.sv
// pipe_fetch_queue shared types and build constants.
// Defining FQ_BYPASS_EN enables the empty-queue IF->ID bypass.
package pipe_fetch_queue_pkg;

  localparam int FQ_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/pipe_fetch_queue_if.sv
// IF/ID handshake bundle around the fetch queue.
// master = pipeline side, slave = the queue.
interface pipe_fetch_queue_if #(
  parameter int DEPTH = pipe_fetch_queue_pkg::FQ_DEPTH
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             if_valid;
  logic [31:0]      if_pc4;
  logic [31:0]      if_instr;
  logic             if_ready;
  logic             id_valid;
  logic [31:0]      id_pc4;
  logic [31:0]      id_instr;
  logic             id_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, if_valid, if_pc4,
    output if_instr, id_ready,
    input  if_ready, id_valid, id_pc4,
    input  id_instr, count
  );

  modport slave (
    input  flush, if_valid, if_pc4,
    input  if_instr, id_ready,
    output if_ready, id_valid, id_pc4,
    output id_instr, count
  );
endinterface

// File: rtl/pipe_fetch_queue_fq_mem.sv
// fq_mem: DEPTH x 64-bit storage for the fetch queue,
// one synchronous write port, one asynchronous read port.
module fq_mem
  import pipe_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      i_we,
  input  logic [AW-1:0] i_waddr,
  input  fq_entry_t i_wdata,
  input  logic [AW-1:0] i_raddr,
  output fq_entry_t o_rdata
);

  fq_entry_t r_mem [DEPTH];

  // write port; contents need no reset
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_fetch_queue.sv
// pipe_fetch_queue: IF->ID decoupling FIFO with flush.
// Optional macro FQ_BYPASS_EN: zero-latency path when empty.
module pipe_fetch_queue
  import pipe_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH
) (
  input logic clk,
  input logic rst,
  pipe_fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C =
    CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_count;

  logic      w_full;
  logic      w_empty;
  logic      w_byp;
  logic      w_push;
  logic      w_pop;
  fq_entry_t w_head;
  fq_entry_t w_in;

  assign w_full  = (r_count == FULL_C);
  assign w_empty = (r_count == '0);
  assign w_in    = '{pc4: bus.if_pc4,
                     instr: bus.if_instr};

`ifdef FQ_BYPASS_EN
  assign w_byp = w_empty && bus.if_valid
              && !bus.flush;
`else
  assign w_byp = 1'b0;
`endif

  // a bypassed pair taken by ID is never stored
  assign w_push = bus.if_valid && !w_full
               && !bus.flush
               && !(w_byp && bus.id_ready);
  assign w_pop  = !w_empty && bus.id_ready
               && !bus.flush;

  assign bus.if_ready = !w_full;
  assign bus.count    = r_count;

  fq_mem #(.DEPTH(DEPTH), .AW(PTR_W)) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wp),
    .i_wdata (w_in),
    .i_raddr (r_rp),
    .o_rdata (w_head)
  );

  // ID view: head entry, bypassed pair, or NOP bubble
  always_comb begin
    bus.id_valid = 1'b0;
    bus.id_pc4   = 32'h0;
    bus.id_instr = NOP_INSTR;
    if (!w_empty) begin
      bus.id_valid = 1'b1;
      bus.id_pc4   = w_head.pc4;
      bus.id_instr = w_head.instr;
    end else if (w_byp) begin
      bus.id_valid = 1'b1;
      bus.id_pc4   = bus.if_pc4;
      bus.id_instr = bus.if_instr;
    end
  end

  // pointers and occupancy; flush beats push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
